// File: rtl/dmem_access_unit_if.sv
// LSU-side and data-memory-side handshake bundle for dmem_access_unit.
// master = the access unit, slave = the LSU/memory environment around it.
interface dmem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 6
);
  logic                lsu_valid_i;
  logic                lsu_load_i;
  logic [1:0]          lsu_size_i;
  logic                lsu_unsigned_i;
  logic [ADDR_W-1:0]   lsu_addr_i;
  logic [DATA_W-1:0]   lsu_st_data_i;
  logic [TAG_W-1:0]    lsu_tag_i;
  logic                lsu_read_o;

  logic                dmem_req_o;
  logic                dmem_gnt_i;
  logic                dmem_we_o;
  logic [DATA_W/8-1:0] dmem_be_o;
  logic [ADDR_W-1:0]   dmem_addr_o;
  logic [DATA_W-1:0]   dmem_wdata_o;
  logic                dmem_rvalid_i;
  logic [DATA_W-1:0]   dmem_rdata_i;

  modport master (
    input  lsu_valid_i, lsu_load_i, lsu_size_i, lsu_unsigned_i,
           lsu_addr_i, lsu_st_data_i, lsu_tag_i,
    output lsu_read_o,
    output dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    output lsu_valid_i, lsu_load_i, lsu_size_i, lsu_unsigned_i,
           lsu_addr_i, lsu_st_data_i, lsu_tag_i,
    input  lsu_read_o,
    input  dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Pipelined LSU-to-data-memory bridge: up to MAX_OUTST in-order requests,
// lane steering, load extension, CDB broadcast, misalign reporting and flush.
module dmem_access_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int TAG_W     = 6
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  dmem_access_unit_if.master bus,
  output logic [TAG_W-1:0]   cdb_tag_o,
  output logic [DATA_W-1:0]  cdb_val_o,
  output logic               misalign_o,
  output logic [TAG_W-1:0]   misalign_tag_o,
  output logic               busy_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [TAG_W-1:0] NO_VAL = '1;

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic             load;
    logic [TAG_W-1:0] tag;
    logic [1:0]       size;
    logic             uns;
    logic [OFF_W-1:0] off;
  } entry_t;

  state_t               r_state, w_state_nxt;
  entry_t               r_fifo [MAX_OUTST];
  logic [MAX_OUTST-1:0] r_kill;
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count, w_count_nxt;

  logic [TAG_W-1:0]     r_cdb_tag;
  logic [DATA_W-1:0]    r_cdb_val;
  logic                 r_misalign;
  logic [TAG_W-1:0]     r_mis_tag;

  logic                 w_aligned, w_run, w_has_room;
  logic                 w_push, w_pop, w_misalign, w_bcast;
  logic [OFF_W-1:0]     w_off;
  logic [BYTES-1:0]     w_lane_mask;
  entry_t               w_head;
  logic [DATA_W-1:0]    w_shift, w_ext;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- issue side ----------------
  always_comb begin
    w_aligned = 1'b0;
    case (bus.lsu_size_i)
      2'b00: w_aligned = 1'b1;
      2'b01: w_aligned = ~bus.lsu_addr_i[0];
      2'b10: w_aligned = (bus.lsu_addr_i[1:0] == 2'b00);
      2'b11: w_aligned = (DATA_W == 64) && (bus.lsu_addr_i[2:0] == 3'b000);
      default: w_aligned = 1'b0;
    endcase
  end

  always_comb begin
    w_lane_mask = '0;
    case (bus.lsu_size_i)
      2'b00: w_lane_mask = BYTES'(1);
      2'b01: w_lane_mask = BYTES'(3);
      2'b10: w_lane_mask = BYTES'(15);
      default: w_lane_mask = '1;
    endcase
  end

  // Reset gates the combinational outputs so they read idle while reset_i is held.
  assign w_run      = (r_state == RUN) && !reset_i;
  assign w_has_room = (r_count < CNT_W'(MAX_OUTST));
  assign w_off      = bus.lsu_addr_i[OFF_W-1:0];

  assign bus.dmem_req_o   = bus.lsu_valid_i & w_aligned & w_has_room & w_run;
  assign w_push           = bus.dmem_req_o & bus.dmem_gnt_i;
  assign w_misalign       = bus.lsu_valid_i & ~w_aligned & w_run;
  assign bus.lsu_read_o   = w_push | w_misalign;

  assign bus.dmem_we_o    = ~bus.lsu_load_i;
  assign bus.dmem_addr_o  = {bus.lsu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.dmem_be_o    = bus.lsu_load_i ? '1 : (w_lane_mask << w_off);
  assign bus.dmem_wdata_o = bus.lsu_st_data_i << {w_off, 3'b000};

  // ---------------- response side ----------------
  assign w_pop   = bus.dmem_rvalid_i & (r_count != '0);
  assign w_head  = r_fifo[r_rd_ptr];
  assign w_shift = bus.dmem_rdata_i >> {w_head.off, 3'b000};
  // A head popping in the flush cycle is squashed along with the rest.
  assign w_bcast = w_pop & w_head.load & ~r_kill[r_rd_ptr] & ~flush_i;

  always_comb begin
    w_ext = w_shift;
    case (w_head.size)
      2'b00: w_ext = w_head.uns ? DATA_W'(w_shift[7:0])  : DATA_W'($signed(w_shift[7:0]));
      2'b01: w_ext = w_head.uns ? DATA_W'(w_shift[15:0]) : DATA_W'($signed(w_shift[15:0]));
      2'b10: w_ext = w_head.uns ? DATA_W'(w_shift[31:0]) : DATA_W'($signed(w_shift[31:0]));
      default: w_ext = w_shift;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // ---------------- FSM ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (flush_i && (w_count_nxt != '0)) w_state_nxt = DRAIN;
      DRAIN:   if (r_count == '0) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= RUN;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_kill     <= '0;
      r_cdb_tag  <= NO_VAL;
      r_cdb_val  <= '0;
      r_misalign <= 1'b0;
      r_mis_tag  <= NO_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (flush_i) r_kill <= '1;
      if (w_push)  r_kill[r_wr_ptr] <= flush_i;
      r_cdb_tag  <= w_bcast ? w_head.tag : NO_VAL;
      r_cdb_val  <= w_bcast ? w_ext : '0;
      r_misalign <= w_misalign;
      r_mis_tag  <= (w_misalign && bus.lsu_load_i) ? bus.lsu_tag_i : NO_VAL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{load: bus.lsu_load_i, tag: bus.lsu_tag_i,
                            size: bus.lsu_size_i, uns: bus.lsu_unsigned_i,
                            off: w_off};
    end
  end

  assign cdb_tag_o      = r_cdb_tag;
  assign cdb_val_o      = r_cdb_val;
  assign misalign_o     = r_misalign;
  assign misalign_tag_o = r_mis_tag;
  assign busy_o         = (r_count != '0);

endmodule
